lock_table: RTL and testbench

Multi-lock arbiter for the OmpSs manager: serves lock/unlock commands for NUM_LOCKS independent lock IDs arriving from accelerators on one AXI-Stream and returns an ACK/REJECT word to the requester. It records the owning accelerator per lock and honours an unlock only from the owner. It sits between the accelerator command interconnect (TID = source accelerator) and the ack return path (TDEST = same accelerator).

---
 rtl/lock_table_pkg.sv | 29 ++
 rtl/lock_table.sv | 158 +++++++++++++++
 tb/tb_lock_table.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_table_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lock_table_pkg
// Description : Shared OmpSs manager command/ack encodings used by the lock
//               arbiter. The header word field positions and the command and
//               ack codes live here.
// Revision    : 1.0 - initial release
// ============================================================================
package lock_table_pkg;

    // Command header field positions within the 64-bit TDATA word
    localparam int CMD_TYPE_L   = 0;
    localparam int CMD_TYPE_H   = 7;
    localparam int LOCK_ID_L    = 8;
    localparam int LOCK_ID_H    = 15;
    localparam int LOCK_ID_BITS = LOCK_ID_H - LOCK_ID_L + 1;
    localparam int CMD_BITS     = CMD_TYPE_H - CMD_TYPE_L + 1;
    localparam int ACK_BITS     = 8;

    // Command codes
    localparam logic [CMD_BITS-1:0] CMD_LOCK_CODE   = 8'h04;
    localparam logic [CMD_BITS-1:0] CMD_UNLOCK_CODE = 8'h05;

    // Ack codes returned in the low byte of the ack word
    localparam logic [ACK_BITS-1:0] ACK_OK_CODE     = 8'h01;
    localparam logic [ACK_BITS-1:0] ACK_REJECT_CODE = 8'h02;

endpackage
`default_nettype wire

// File: rtl/lock_table.sv
`default_nettype none
// ============================================================================
// Module      : lock_table
// Description : Multi-lock arbiter. Accepts lock/unlock command headers from
//               accelerators on an AXI-Stream, records the owner of each lock
//               and answers lock requests with an ACK_OK / ACK_REJECT word
//               routed back to the requesting accelerator.
// Ports       : clk, rstn (sync, active-low)
//               inStream_*  : command input  (TID = requesting accelerator)
//               outStream_* : ack output     (TDEST = requesting accelerator)
//               lock_busy   : per-lock held flag (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module lock_table
    import lock_table_pkg::*;
#(
    parameter int ACC_BITS  = 4,
    parameter int NUM_LOCKS = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [63:0]          inStream_TDATA,
    input  logic                 inStream_TVALID,
    input  logic [ACC_BITS-1:0]  inStream_TID,
    output logic                 inStream_TREADY,
    output logic [63:0]          outStream_TDATA,
    output logic                 outStream_TVALID,
    input  logic                 outStream_TREADY,
    output logic                 outStream_TLAST,
    output logic [ACC_BITS-1:0]  outStream_TDEST,
    output logic [NUM_LOCKS-1:0] lock_busy
);

    // Lock ID field must be able to address every lock
    if (NUM_LOCKS < 1 || NUM_LOCKS > 2**LOCK_ID_BITS) begin : g_bad_num_locks
        $error("lock_table: NUM_LOCKS must be in 1..2**LOCK_ID_BITS");
    end

    typedef enum logic [1:0] {
        ST_READ_HEADER = 2'd0,
        ST_CHECK_LOCK  = 2'd1,
        ST_SEND_ACK    = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [ACK_BITS-1:0]   r_ack_code;
    logic [ACC_BITS-1:0]   r_dest;
    logic [ACC_BITS-1:0]   r_tid;
    logic [CMD_BITS-1:0]   r_cmd;
    logic [LOCK_ID_BITS-1:0] r_lock_id;
    logic [NUM_LOCKS-1:0]  r_held;
    logic [ACC_BITS-1:0]   r_owner [NUM_LOCKS];

    logic [NUM_LOCKS-1:0]  w_sel;        // one-hot decode of latched lock ID
    logic                  w_sel_held;
    logic [ACC_BITS-1:0]   w_sel_owner;
    logic                  w_lock_ok;
    logic                  w_unlock_ok;
    logic                  w_do_lock;
    logic                  w_unused_tdata;

    // Decoding by comparison rather than indexing: an out-of-range ID simply
    // matches no lock, so no separate range check is needed.
    always_comb begin
        w_sel       = '0;
        w_sel_owner = '0;
        for (int i = 0; i < NUM_LOCKS; i++) begin
            if (r_lock_id == LOCK_ID_BITS'(i)) begin
                w_sel[i]    = 1'b1;
                w_sel_owner = r_owner[i];
            end
        end
    end

    assign w_sel_held  = |(r_held & w_sel);
    assign w_lock_ok   = (|w_sel) & ~w_sel_held;
    assign w_unlock_ok = w_sel_held & (w_sel_owner == r_tid);
    assign w_do_lock   = (r_state == ST_CHECK_LOCK) && (r_cmd == CMD_LOCK_CODE) && w_lock_ok;

    // Payload bits above the lock ID carry nothing this block uses
    assign w_unused_tdata = ^inStream_TDATA[63:LOCK_ID_H+1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_READ_HEADER;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ack_code  <= '0;
            r_dest      <= '0;
            r_tid       <= '0;
            r_cmd       <= '0;
            r_lock_id   <= '0;
            r_held      <= '0;
        end else begin
            case (r_state)
                ST_READ_HEADER: begin
                    if (inStream_TVALID && r_in_ready) begin
                        r_tid      <= inStream_TID;
                        r_cmd      <= inStream_TDATA[CMD_TYPE_H:CMD_TYPE_L];
                        r_lock_id  <= inStream_TDATA[LOCK_ID_H:LOCK_ID_L];
                        r_in_ready <= 1'b0;
                        r_state    <= ST_CHECK_LOCK;
                    end
                end
                ST_CHECK_LOCK: begin
                    if (r_cmd == CMD_LOCK_CODE) begin
                        r_dest      <= r_tid;
                        r_ack_code  <= w_lock_ok ? ACK_OK_CODE : ACK_REJECT_CODE;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_SEND_ACK;
                        if (w_lock_ok) begin
                            r_held <= r_held | w_sel;
                        end
                    end else begin
                        // Unlock and unknown commands produce no ack
                        r_in_ready <= 1'b1;
                        r_state    <= ST_READ_HEADER;
                        if (r_cmd == CMD_UNLOCK_CODE && w_unlock_ok) begin
                            r_held <= r_held & ~w_sel;
                        end
                    end
                end
                ST_SEND_ACK: begin
                    if (outStream_TREADY) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_READ_HEADER;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_READ_HEADER;
                end
            endcase
        end
    end

    // Owner table needs no reset: it is only consulted while held is set
    for (genvar g = 0; g < NUM_LOCKS; g++) begin : g_owner
        always_ff @(posedge clk) begin
            if (rstn && w_do_lock && w_sel[g]) begin
                r_owner[g] <= r_tid;
            end
        end
    end

    assign inStream_TREADY  = r_in_ready;
    assign outStream_TVALID = r_out_valid;
    assign outStream_TDATA  = {{(64-ACK_BITS){1'b0}}, r_ack_code};
    assign outStream_TDEST  = r_dest;
    assign outStream_TLAST  = 1'b1;
    assign lock_busy        = r_held;

endmodule
`default_nettype wire

// File: tb/tb_lock_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_table
// Description : Self-checking bench for lock_table: directed vector table,
//               hand-written backpressure and reset sequences, and random
//               commands checked against a behavioural lock model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_table;
    import lock_table_pkg::*;

    localparam int ACC_BITS  = 4;
    localparam int NUM_LOCKS = 16;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [63:0]          in_data;
    logic                 in_valid;
    logic [ACC_BITS-1:0]  in_tid;
    logic                 in_ready;
    logic [63:0]          out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [ACC_BITS-1:0]  out_dest;
    logic [NUM_LOCKS-1:0] busy;

    lock_table #(.ACC_BITS(ACC_BITS), .NUM_LOCKS(NUM_LOCKS)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .inStream_TDATA   (in_data),
        .inStream_TVALID  (in_valid),
        .inStream_TID     (in_tid),
        .inStream_TREADY  (in_ready),
        .outStream_TDATA  (out_data),
        .outStream_TVALID (out_valid),
        .outStream_TREADY (out_ready),
        .outStream_TLAST  (out_last),
        .outStream_TDEST  (out_dest),
        .lock_busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_held  [NUM_LOCKS];
    int m_owner [NUM_LOCKS];

    task automatic model_clear();
        for (int i = 0; i < NUM_LOCKS; i++) begin
            m_held[i]  = 1'b0;
            m_owner[i] = -1;
        end
    endtask

    function automatic logic [15:0] model_busy();
        logic [15:0] b = '0;
        for (int i = 0; i < NUM_LOCKS; i++) b[i] = m_held[i];
        return b;
    endfunction

    // Applies one command to the model; returns whether an ack is due and its code
    task automatic model_apply(input int acc, input logic [7:0] code, input int id,
                               output bit exp_ack, output logic [7:0] exp_code);
        exp_ack  = 1'b0;
        exp_code = '0;
        if (code == CMD_LOCK_CODE) begin
            exp_ack = 1'b1;
            if (id < NUM_LOCKS && !m_held[id]) begin
                exp_code    = ACK_OK_CODE;
                m_held[id]  = 1'b1;
                m_owner[id] = acc;
            end else begin
                exp_code = ACK_REJECT_CODE;
            end
        end else if (code == CMD_UNLOCK_CODE) begin
            if (id < NUM_LOCKS && m_held[id] && m_owner[id] == acc) m_held[id] = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_hdr(input logic [3:0] acc, input logic [7:0] code, input logic [7:0] id);
        in_valid = 1'b1;
        in_tid   = acc;
        in_data  = {$urandom(), $urandom()};
        in_data[15:8] = id;
        in_data[7:0]  = code;
    endtask

    // Waits at negedges for TREADY; returns 0 on timeout
    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (!ok) chk("hdr_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // Issues one command with out_ready high and checks the cycle-level timing.
    task automatic do_cmd(input logic [3:0] acc, input logic [7:0] code, input logic [7:0] id,
                          output bit got_ack, output logic [7:0] ack, output logic [3:0] dest);
        logic [15:0] busy_before;
        bit ok;
        got_ack = 1'b0;
        ack     = '0;
        dest    = '0;
        @(negedge clk);
        drive_hdr(acc, code, id);
        wait_ready(ok);
        if (!ok) begin
            in_valid = 1'b0;
            return;
        end
        busy_before = busy;
        @(negedge clk);                         // handshake edge has passed
        in_valid = 1'b0;
        chk("check_state_tready_low", 64'(in_ready), 64'd0);
        chk("busy_not_yet_updated", 64'(busy), 64'(busy_before));
        @(negedge clk);
        if (out_valid) begin
            got_ack = 1'b1;
            ack     = out_data[7:0];
            dest    = out_dest;
            chk("ack_upper_zero", out_data[63:8], 64'd0);
            chk("ack_tlast", 64'(out_last), 64'd1);
            chk("ack_tready_low", 64'(in_ready), 64'd0);
            @(negedge clk);
            chk("after_ack_tready", 64'(in_ready), 64'd1);
            chk("after_ack_valid", 64'(out_valid), 64'd0);
        end else begin
            chk("no_ack_tready_t2", 64'(in_ready), 64'd1);
        end
    endtask

    task automatic run_chk(input string name, input logic [3:0] acc, input logic [7:0] code,
                           input logic [7:0] id, input bit exp_ack, input logic [7:0] exp_code,
                           input logic [15:0] exp_busy);
        bit          got_ack;
        logic [7:0]  ack;
        logic [3:0]  dest;
        do_cmd(acc, code, id, got_ack, ack, dest);
        chk($sformatf("%s_ack_present", name), 64'(got_ack), 64'(exp_ack));
        if (exp_ack && got_ack) begin
            chk($sformatf("%s_ack_code", name), 64'(ack), 64'(exp_code));
            chk($sformatf("%s_ack_dest", name), 64'(dest), 64'(acc));
        end
        chk($sformatf("%s_lock_busy", name), 64'(busy), 64'(exp_busy));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_clear();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0]  acc;
        logic [7:0]  code;
        logic [7:0]  id;
        bit          exp_ack;
        logic [7:0]  exp_code;
        logic [15:0] exp_busy;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          exp_ack;
        logic [7:0]  exp_code;
        logic [63:0] exp_word;
        bit          ok;

        vecs[0]  = '{4'd2, CMD_LOCK_CODE,   8'd3,  1'b1, ACK_OK_CODE,     16'h0008};
        vecs[1]  = '{4'd5, CMD_LOCK_CODE,   8'd3,  1'b1, ACK_REJECT_CODE, 16'h0008};
        vecs[2]  = '{4'd5, CMD_UNLOCK_CODE, 8'd3,  1'b0, 8'h00,           16'h0008};
        vecs[3]  = '{4'd2, CMD_UNLOCK_CODE, 8'd3,  1'b0, 8'h00,           16'h0000};
        vecs[4]  = '{4'd5, CMD_LOCK_CODE,   8'd3,  1'b1, ACK_OK_CODE,     16'h0008};
        vecs[5]  = '{4'd1, CMD_LOCK_CODE,   8'd0,  1'b1, ACK_OK_CODE,     16'h0009};
        vecs[6]  = '{4'd1, CMD_LOCK_CODE,   8'd0,  1'b1, ACK_REJECT_CODE, 16'h0009};
        vecs[7]  = '{4'd6, CMD_LOCK_CODE,   8'd7,  1'b1, ACK_OK_CODE,     16'h0089};
        vecs[8]  = '{4'd3, CMD_LOCK_CODE,   8'd16, 1'b1, ACK_REJECT_CODE, 16'h0089};
        vecs[9]  = '{4'd3, CMD_UNLOCK_CODE, 8'd16, 1'b0, 8'h00,           16'h0089};
        vecs[10] = '{4'd3, 8'h33,           8'd2,  1'b0, 8'h00,           16'h0089};
        vecs[11] = '{4'd5, CMD_UNLOCK_CODE, 8'd3,  1'b0, 8'h00,           16'h0081};
        vecs[12] = '{4'd1, CMD_UNLOCK_CODE, 8'd0,  1'b0, 8'h00,           16'h0080};
        vecs[13] = '{4'd6, CMD_UNLOCK_CODE, 8'd7,  1'b0, 8'h00,           16'h0000};

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_tid    = '0;
        in_data   = '0;
        out_ready = 1'b1;
        do_reset();

        // Reset state, first cycle after deassertion
        chk("rst_tready", 64'(in_ready), 64'd1);
        chk("rst_tvalid", 64'(out_valid), 64'd0);
        chk("rst_tdata", out_data, 64'd0);
        chk("rst_tdest", 64'(out_dest), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_chk($sformatf("vec%0d", i), vecs[i].acc, vecs[i].code, vecs[i].id,
                    vecs[i].exp_ack, vecs[i].exp_code, vecs[i].exp_busy);
        end

        // Ack backpressure: acc 4 locks ID 9 with the ack path stalled
        out_ready = 1'b0;
        @(negedge clk);
        drive_hdr(4'd4, CMD_LOCK_CODE, 8'd9);
        wait_ready(ok);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        exp_word = {56'd0, ACK_OK_CODE};
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_valid_%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp_data_%0d", i), out_data, exp_word);
            chk($sformatf("bp_dest_%0d", i), 64'(out_dest), 64'd4);
            chk($sformatf("bp_tready_%0d", i), 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_tready", 64'(in_ready), 64'd1);
        model_apply(4, CMD_LOCK_CODE, 9, exp_ack, exp_code);
        chk("bp_busy", 64'(busy), 64'(model_busy()));

        // Random commands against the model; few accs/IDs to force collisions
        for (int n = 0; n < 300; n++) begin
            int          acc;
            int          id;
            int          r;
            logic [7:0]  code;
            acc  = $urandom_range(0, 3);
            id   = $urandom_range(0, NUM_LOCKS + 1);
            r    = $urandom_range(0, 9);
            code = (r < 5) ? CMD_LOCK_CODE : (r < 9) ? CMD_UNLOCK_CODE : 8'h77;
            model_apply(acc, code, id, exp_ack, exp_code);
            run_chk($sformatf("rnd%0d", n), 4'(acc), code, 8'(id), exp_ack, exp_code, model_busy());
        end

        // Reset while an ack is pending with locks 1 and 4 held
        do_reset();
        run_chk("rs_lock1", 4'd2, CMD_LOCK_CODE, 8'd1, 1'b1, ACK_OK_CODE, 16'h0002);
        run_chk("rs_lock4", 4'd3, CMD_LOCK_CODE, 8'd4, 1'b1, ACK_OK_CODE, 16'h0012);
        out_ready = 1'b0;
        @(negedge clk);
        drive_hdr(4'd6, CMD_LOCK_CODE, 8'd5);
        wait_ready(ok);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rs_pending_valid", 64'(out_valid), 64'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("rs_valid_dropped", 64'(out_valid), 64'd0);
        chk("rs_busy_cleared", 64'(busy), 64'd0);
        chk("rs_tdata_cleared", out_data, 64'd0);
        rstn      = 1'b1;
        out_ready = 1'b1;
        model_clear();
        run_chk("rs_relock1", 4'd7, CMD_LOCK_CODE, 8'd1, 1'b1, ACK_OK_CODE, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
